// File: rtl/emitter_pkg.sv
// Shared types and constants for the emitter TX arbiter slice.
// Latency: none, definitions only.
// Backpressure: none, definitions only.
package emitter_pkg;

   localparam int UART_BYTE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   // Width of a register that must hold 0..n-1; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester at or after the pointer, wrapping N-1 -> 0.
// Latency: purely combinational; the owning FSM registers the result.
// Backpressure: none, it only observes the request vector.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   logic [2*N-1:0] w_req2;
   logic [N-1:0]   w_rot;

   // Rotating a doubled copy puts the pointer slot at bit 0 without wrap logic.
   assign w_req2 = {i_req, i_req};
   assign w_rot  = N'(w_req2 >> i_ptr);
   assign o_any  = |i_req;

   // Lowest set bit of the rotated vector wins; map it back to an absolute index.
   always_comb begin
      logic        v_found;
      logic [IW:0] v_sum;
      o_gnt   = '0;
      o_idx   = '0;
      v_found = 1'b0;
      v_sum   = '0;
      for (int off = 0; off < N; off++) begin
         if (!v_found && w_rot[off]) begin
            v_found = 1'b1;
            v_sum   = {1'b0, i_ptr} + (IW+1)'(off);
            if (v_sum >= (IW+1)'(N)) begin
               v_sum = v_sum - (IW+1)'(N);
            end
            o_idx = v_sum[IW-1:0];
         end
      end
      if (v_found) begin
         o_gnt[o_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/emitter_tx_arbiter.sv
// Packet-granular round-robin share of one byte-wide UART TX among N requesters.
// Latency: grant registered 1 cycle after a request in IDLE; bytes then pass combinationally.
// Backpressure: owner's o_ready mirrors i_tx_ready; non-owners are never acked.
module emitter_tx_arbiter
   import emitter_pkg::*;
#(
   parameter int N          = 4,
   parameter int MAX_LEN    = 256,
   parameter int GAP_CYCLES = 0
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [UART_BYTE_W*N-1:0] i_data,
   input  logic [N-1:0]             i_valid,
   input  logic [N-1:0]             i_last,
   output logic [N-1:0]             o_ready,
   output logic [UART_BYTE_W-1:0]   o_tx_data,
   output logic                     o_tx_valid,
   input  logic                     i_tx_ready,
   output logic [N-1:0]             o_grant,
   output logic                     o_busy,
   output logic                     o_err
);

   localparam int IW = idx_width(N);
   localparam int CW = idx_width(MAX_LEN);
   localparam int GW = idx_width(GAP_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(MAX_LEN - 1);
   localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

   state_t          r_state;
   logic [IW-1:0]   r_ptr;
   logic [IW-1:0]   r_gidx;
   logic [N-1:0]    r_grant;
   logic [CW-1:0]   r_cnt;
   logic [GW-1:0]   r_gap;
   logic            r_busy;

   logic [N-1:0]    w_arb_gnt;
   logic [IW-1:0]   w_arb_idx;
   logic            w_arb_any;
   logic            w_in_busy;
   logic            w_own_valid;
   logic            w_own_last;
   logic            w_xfer;
   logic            w_wd_hit;
   logic            w_pkt_end;
   logic [IW-1:0]   w_next_ptr;
   logic [UART_BYTE_W-1:0] w_tx_data;

   rr_arbiter #(
      .N  (N),
      .IW (IW)
   ) u_rr (
      .i_req (i_valid),
      .i_ptr (r_ptr),
      .o_gnt (w_arb_gnt),
      .o_idx (w_arb_idx),
      .o_any (w_arb_any)
   );

   // r_grant is only non-zero in BUSY, so masking with it also gates outside BUSY.
   assign w_in_busy   = (r_state == ST_BUSY);
   assign w_own_valid = w_in_busy & |(i_valid & r_grant);
   assign w_own_last  = |(i_last & r_grant);
   assign w_xfer      = w_own_valid & i_tx_ready;
   assign w_wd_hit    = (r_cnt == CNT_LAST);
   assign w_pkt_end   = w_xfer & (w_own_last | w_wd_hit);
   assign w_next_ptr  = (r_gidx == IW'(N - 1)) ? '0 : r_gidx + IW'(1);

   // Owner byte select as an AND-OR mux over the one-hot grant.
   always_comb begin
      w_tx_data = '0;
      for (int k = 0; k < N; k++) begin
         if (r_grant[k]) begin
            w_tx_data = w_tx_data | i_data[k*UART_BYTE_W +: UART_BYTE_W];
         end
      end
   end

   assign o_tx_data  = w_in_busy ? w_tx_data : '0;
   assign o_tx_valid = w_own_valid;
   assign o_ready    = r_grant & {N{w_in_busy & i_tx_ready}};
   assign o_grant    = r_grant;
   assign o_busy     = r_busy;
   // Watchdog pulse coincides with the accept of the MAX_LEN-th byte; a last flag on it wins.
   assign o_err      = w_xfer & w_wd_hit & ~w_own_last;

   // Arbitrate in IDLE, count bytes in BUSY, sit out the gap, then rearm.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_ptr   <= '0;
         r_gidx  <= '0;
         r_grant <= '0;
         r_cnt   <= '0;
         r_gap   <= '0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_arb_any) begin
                  r_state <= ST_BUSY;
                  r_gidx  <= w_arb_idx;
                  r_grant <= w_arb_gnt;
                  r_busy  <= 1'b1;
               end
            end
            ST_BUSY: begin
               if (w_pkt_end) begin
                  r_cnt   <= '0;
                  r_ptr   <= w_next_ptr;
                  r_grant <= '0;
                  if (GAP_CYCLES > 0) begin
                     r_state <= ST_GAP;
                     r_gap   <= GAP_LOAD;
                  end else begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end
               end else if (w_xfer) begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            ST_GAP: begin
               if (r_gap == '0) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_gap <= r_gap - GW'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_grant <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_emitter_tx_arbiter.sv
// Bench for emitter_tx_arbiter: packet-level reference model plus directed scenarios.
// Latency: model predicts outputs each cycle from owner/pointer/gap bookkeeping.
// Backpressure: UART modelled as busy for 10 cycles after every accepted byte.
module tb_emitter_tx_arbiter;

   localparam int NR  = 4;
   localparam int ML  = 4;
   localparam int GAP = 5;

   logic            clk;
   logic            i_rst;
   logic [8*NR-1:0] i_data;
   logic [NR-1:0]   i_valid;
   logic [NR-1:0]   i_last;
   logic [NR-1:0]   o_ready;
   logic [7:0]      o_tx_data;
   logic            o_tx_valid;
   logic            i_tx_ready;
   logic [NR-1:0]   o_grant;
   logic            o_busy;
   logic            o_err;

   emitter_tx_arbiter #(.N(NR), .MAX_LEN(ML), .GAP_CYCLES(GAP)) dut (
      .i_clk      (clk),
      .i_rst      (i_rst),
      .i_data     (i_data),
      .i_valid    (i_valid),
      .i_last     (i_last),
      .o_ready    (o_ready),
      .o_tx_data  (o_tx_data),
      .o_tx_valid (o_tx_valid),
      .i_tx_ready (i_tx_ready),
      .o_grant    (o_grant),
      .o_busy     (o_busy),
      .o_err      (o_err)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Sources: per requester, queue of {last, byte}.
   logic [8:0] src [NR][$];
   bit         hold [NR];
   bit         rand_hold = 0;
   int         uart_cnt = 0;

   // Reference model: who owns the TX, where the pointer sits, bytes so far, gap cycles left.
   int m_owner = -1;
   int m_ptr   = 0;
   int m_cnt   = 0;
   int m_gap   = 0;

   // Observations of the DUT for the directed literal checks.
   int          glog [$];
   logic [7:0]  blog [$];
   logic [1:0]  trace [$];
   int          exp_g [$];
   logic [7:0]  exp_b [$];
   int          err_cnt = 0;
   logic [7:0]  err_byte = 8'h00;
   int          rdy3_cnt = 0;
   logic [NR-1:0] prev_gnt = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int onehot_idx(input logic [NR-1:0] v);
      if ($countones(v) != 1) return 99;
      for (int k = 0; k < NR; k++) if (v[k]) return k;
      return 99;
   endfunction

   // Compare DUT outputs against the model, record observations, then advance the model
   // to the state it must hold after the coming rising edge.
   task automatic env_step();
      logic [NR-1:0] eg, er;
      logic [7:0]    ed;
      logic          ev, eb, ee, xf, lst;
      logic [8:0]    ent;
      if (i_rst) begin
         m_owner = -1; m_ptr = 0; m_cnt = 0; m_gap = 0; uart_cnt = 0; prev_gnt = '0;
         chk("rst_grant", 32'(o_grant), 32'd0);
         chk("rst_busy_valid_err", {29'd0, o_busy, o_tx_valid, o_err}, 32'd0);
         chk("rst_ready_data", {20'd0, o_ready, o_tx_data}, 32'd0);
         return;
      end
      eg = '0; er = '0; ed = 8'h00; ev = 1'b0;
      if (m_owner >= 0) begin
         eg[m_owner] = 1'b1;
         ev = i_valid[m_owner];
         ed = i_data[8*m_owner +: 8];
         if (i_tx_ready) er = eg;
      end
      eb  = (m_owner >= 0) || (m_gap > 0);
      xf  = ev && i_tx_ready;
      lst = xf && i_last[m_owner];
      ee  = xf && !lst && (m_cnt + 1 == ML);
      chk("grant", 32'(o_grant), 32'(eg));
      chk("busy", 32'(o_busy), 32'(eb));
      chk("tx_valid", 32'(o_tx_valid), 32'(ev));
      chk("ready", 32'(o_ready), 32'(er));
      chk("tx_data", 32'(o_tx_data), 32'(ed));
      chk("err", 32'(o_err), 32'(ee));

      if (o_grant != '0 && prev_gnt == '0) glog.push_back(onehot_idx(o_grant));
      prev_gnt = o_grant;
      if (o_tx_valid && i_tx_ready) blog.push_back(o_tx_data);
      if (o_err) begin
         err_cnt++;
         if (o_tx_valid && i_tx_ready) err_byte = o_tx_data;
      end
      if (o_ready[3]) rdy3_cnt++;
      trace.push_back({o_busy, |o_grant});

      if (m_owner < 0 && m_gap == 0) begin
         for (int off = 0; off < NR; off++) begin
            if (m_owner < 0 && i_valid[(m_ptr + off) % NR]) m_owner = (m_ptr + off) % NR;
         end
      end else if (m_owner >= 0) begin
         if (xf) begin
            m_cnt++;
            if (src[m_owner].size() > 0) ent = src[m_owner].pop_front();
            if (lst || m_cnt == ML) begin
               m_ptr   = (m_owner + 1) % NR;
               m_owner = -1;
               m_cnt   = 0;
               m_gap   = GAP;
            end
         end
      end else begin
         m_gap--;
      end
      if (xf) uart_cnt = 10;
      else if (uart_cnt > 0) uart_cnt--;
   endtask

   task automatic drive_inputs();
      logic [8:0] ent;
      for (int k = 0; k < NR; k++) begin
         if (rand_hold) hold[k] = ($urandom_range(0, 7) == 0);
         if (src[k].size() > 0 && !hold[k]) begin
            ent = src[k][0];
            i_valid[k]       = 1'b1;
            i_data[8*k +: 8] = ent[7:0];
            i_last[k]        = ent[8];
         end else begin
            i_valid[k]       = 1'b0;
            i_data[8*k +: 8] = 8'($urandom);
            i_last[k]        = 1'($urandom);
         end
      end
      i_tx_ready = (uart_cnt == 0);
   endtask

   initial begin
      i_valid = '0; i_data = '0; i_last = '0; i_tx_ready = 1'b0;
      forever begin
         @(negedge clk);
         env_step();
         @(posedge clk);
         #1;
         drive_inputs();
      end
   end

   task automatic clear_all();
      for (int k = 0; k < NR; k++) begin
         src[k].delete();
         hold[k] = 0;
      end
   endtask

   task automatic clear_logs();
      glog.delete(); blog.delete(); trace.delete();
      err_cnt = 0; err_byte = 8'h00; rdy3_cnt = 0;
   endtask

   task automatic do_reset();
      @(negedge clk); #2;
      i_rst = 1'b1;
      clear_all();
      repeat (2) @(negedge clk);
      #2;
      i_rst = 1'b0;
      clear_logs();
   endtask

   task automatic push_pkt(input int k, input int len, input logic [7:0] base, input bit with_last);
      for (int j = 0; j < len; j++) begin
         src[k].push_back({(with_last && j == len - 1), 8'(base + 8'(j))});
      end
   endtask

   function automatic bit all_quiet();
      for (int k = 0; k < NR; k++) if (src[k].size() != 0) return 0;
      return (m_owner < 0) && (m_gap == 0);
   endfunction

   task automatic wait_done(input int budget, input string nm);
      int t;
      t = 0;
      while (!all_quiet() && t < budget) begin
         @(negedge clk); #2;
         t++;
      end
      if (!all_quiet()) chk({nm, "_timeout"}, 32'd1, 32'd0);
   endtask

   task automatic wait_bytes(input int n, input int budget, input string nm);
      int t;
      t = 0;
      while (blog.size() < n && t < budget) begin
         @(negedge clk); #2;
         t++;
      end
      if (blog.size() < n) chk({nm, "_timeout"}, 32'(blog.size()), 32'(n));
   endtask

   task automatic check_glog(input string nm);
      chk({nm, "_count"}, 32'(glog.size()), 32'(exp_g.size()));
      for (int i = 0; i < exp_g.size() && i < glog.size(); i++) chk(nm, 32'(glog[i]), 32'(exp_g[i]));
   endtask

   task automatic check_blog(input string nm);
      chk({nm, "_count"}, 32'(blog.size()), 32'(exp_b.size()));
      for (int i = 0; i < exp_b.size() && i < blog.size(); i++) chk(nm, 32'(blog[i]), 32'(exp_b[i]));
   endtask

   initial begin
      #(10 * 80000);
      n_fail++;
      $display("FAIL global_timeout: simulation did not finish, got no end, expected end");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $fatal(1, "global timeout");
   end

   initial begin
      int t, i, gapc, idlec, total;
      i_rst = 1'b1;
      clear_all();
      do_reset();

      // Literal reset values straight out of reset.
      @(negedge clk); #2;
      chk("t0_grant", 32'(o_grant), 32'd0);
      chk("t0_busy", 32'(o_busy), 32'd0);
      chk("t0_txvalid", 32'(o_tx_valid), 32'd0);

      // 1. Async reset mid-packet; next grant goes to requester 0.
      push_pkt(2, 3, 8'h50, 1);
      t = 0;
      while (!(m_owner == 2 && m_cnt >= 1) && t < 200) begin
         @(negedge clk); t++;
      end
      chk("t1_reached_busy", 32'(m_owner), 32'd2);
      @(posedge clk); #3;
      i_rst = 1'b1;
      #1;
      chk("t1_async_grant", 32'(o_grant), 32'd0);
      chk("t1_async_busy", 32'(o_busy), 32'd0);
      chk("t1_async_ready", 32'(o_ready), 32'd0);
      chk("t1_async_txvalid", 32'(o_tx_valid), 32'd0);
      chk("t1_async_data", 32'(o_tx_data), 32'd0);
      chk("t1_async_err", 32'(o_err), 32'd0);
      clear_all();
      repeat (2) @(negedge clk);
      #2;
      i_rst = 1'b0;
      clear_logs();
      push_pkt(0, 1, 8'h60, 1);
      push_pkt(2, 1, 8'h70, 1);
      wait_done(200, "t1");
      exp_g = '{0, 2};
      check_glog("t1_grants");

      // 2. Requesters 0 and 2 each send 3 bytes; packets never interleave.
      do_reset();
      push_pkt(0, 3, 8'hA0, 1);
      push_pkt(2, 3, 8'hC0, 1);
      wait_done(300, "t2");
      exp_g = '{0, 2};
      check_glog("t2_grants");
      exp_b = '{8'hA0, 8'hA1, 8'hA2, 8'hC0, 8'hC1, 8'hC2};
      check_blog("t2_bytes");

      // 3. All four request 1-byte packets continuously; strict rotation with wrap.
      do_reset();
      for (int k = 0; k < NR; k++) begin
         push_pkt(k, 1, 8'(8'h10 * k), 1);
         push_pkt(k, 1, 8'(8'h10 * k + 8'h08), 1);
      end
      wait_done(600, "t3");
      exp_g = '{0, 1, 2, 3, 0, 1, 2, 3};
      check_glog("t3_grants");

      // 4. Watchdog: requester 1 sends 6 bytes with no last flag, requester 2 waits.
      do_reset();
      push_pkt(1, 6, 8'h10, 0);
      push_pkt(2, 1, 8'h2A, 1);
      wait_bytes(7, 600, "t4");
      chk("t4_err_count", 32'(err_cnt), 32'd1);
      chk("t4_err_with_4th", 32'(err_byte), 32'h13);
      exp_g = '{1, 2, 1};
      check_glog("t4_grants");
      exp_b = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h2A, 8'h14, 8'h15};
      check_blog("t4_bytes");

      // 5. Gap: two back-to-back packets from one requester.
      do_reset();
      push_pkt(0, 2, 8'h80, 1);
      push_pkt(0, 2, 8'h90, 1);
      wait_done(400, "t5");
      i = 1;
      while (i < trace.size() && !(trace[i-1][0] && !trace[i][0])) i++;
      gapc = 0;
      while (i < trace.size() && trace[i] == 2'b10) begin gapc++; i++; end
      idlec = 0;
      while (i < trace.size() && trace[i] == 2'b00) begin idlec++; i++; end
      chk("t5_gap_cycles", 32'(gapc), 32'd5);
      chk("t5_idle_cycles", 32'(idlec), 32'd1);
      exp_g = '{0, 0};
      check_glog("t5_grants");

      // 6. Owner stalls 50 cycles while requester 3 waits.
      do_reset();
      push_pkt(0, 3, 8'hB0, 1);
      wait_bytes(1, 200, "t6_first");
      hold[0] = 1;
      push_pkt(3, 1, 8'hD3, 1);
      rdy3_cnt = 0;
      t = 0;
      repeat (50) begin
         @(negedge clk); #2;
         if (o_grant != 4'b0001) t++;
      end
      chk("t6_grant_held", 32'(t), 32'd0);
      chk("t6_ready3_during_stall", 32'(rdy3_cnt), 32'd0);
      hold[0] = 0;
      wait_done(400, "t6");
      exp_g = '{0, 3};
      check_glog("t6_grants");
      exp_b = '{8'hB0, 8'hB1, 8'hB2, 8'hD3};
      check_blog("t6_bytes");

      // 7. Random traffic with random valid stalls, checked cycle by cycle by the model.
      do_reset();
      total = 0;
      rand_hold = 1;
      for (int c = 0; c < 2500; c++) begin
         @(negedge clk); #2;
         if ($urandom_range(0, 9) == 0) begin
            int k, len;
            k = $urandom_range(0, NR - 1);
            len = $urandom_range(1, 5);
            if (src[k].size() < 8) begin
               push_pkt(k, len, 8'($urandom), 1);
               total += len;
            end
         end
      end
      rand_hold = 0;
      for (int k = 0; k < NR; k++) hold[k] = 0;
      wait_done(4000, "t7");
      chk("t7_byte_total", 32'(blog.size()), 32'(total));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
